// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with branch/jump/JR, stall hold, exception entry and ERET
// exl is the only FSM state; pc and epc are datapath registers sharing its reset.
module pc_unit #(
  parameter int          ADDR_W   = 32,
  parameter int          OFFSET_W = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [2:0]          br_type,
  input  logic                cond,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [25:0]         index,
  input  logic [ADDR_W-1:0]   rdata1,
  input  logic                exc_req,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus_4,
  output logic [ADDR_W-1:0]   next_pc,
  output logic [ADDR_W-1:0]   epc,
  output logic                exl,
  output logic                exc_taken
);

  localparam logic [2:0] BR_BRANCH = 3'd1;
  localparam logic [2:0] BR_J      = 3'd2;
  localparam logic [2:0] BR_JR     = 3'd3;
  localparam logic [2:0] BR_ERET   = 3'd4;

  localparam logic [ADDR_W-1:0] RESET_V = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_V   = EXC_PC[ADDR_W-1:0];

  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
  logic              exl_q, exl_d;
  logic [ADDR_W-1:0] off_ext, br_target, j_target;
  logic              misalign, eret_taken;

  assign off_ext   = {{(ADDR_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  assign pc_plus_4 = pc_q + ADDR_W'(4);
  assign br_target = pc_plus_4 + (off_ext << 2);
  assign j_target  = {pc_plus_4[ADDR_W-1:28], index, 2'b00};

  assign misalign   = (br_type == BR_JR) && (rdata1[1:0] != 2'b00);
  assign eret_taken = (br_type == BR_ERET) && exl_q;

  // State register: reset may arrive at any time, including mid-exception.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_V;
      epc_q <= '0;
      exl_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      exl_q <= exl_d;
    end
  end

  // Next-state: exception entry overrides stall; no nesting while exl is set.
  always_comb begin
    exl_d = exl_q;
    pc_d  = pc_q;
    epc_d = epc_q;
    if (exc_taken) begin
      exl_d = 1'b1;
      pc_d  = EXC_V;
      epc_d = pc_q;
    end else if (!stall) begin
      pc_d = next_pc;
      if (eret_taken) exl_d = 1'b0;
    end
  end

  // Outputs: next_pc is shown even while stalled.
  always_comb begin
    exc_taken = !exl_q && (exc_req || misalign);
    next_pc   = pc_plus_4;
    if (exc_taken)                          next_pc = EXC_V;
    else if (eret_taken)                    next_pc = epc_q;
    else if (br_type == BR_BRANCH && cond)  next_pc = br_target;
    else if (br_type == BR_J)               next_pc = j_target;
    else if (br_type == BR_JR)              next_pc = rdata1;
  end

  assign pc  = pc_q;
  assign epc = epc_q;
  assign exl = exl_q;

endmodule
